// File: rtl/jtag_dbg_pkg.sv
// Shared helpers for the system-clock side of the CPU JTAG debug module.
package jtag_dbg_pkg;

    // Ceiling log2, used to size FIFO pointers from the buffer depth.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // The action flag always lives in the MSB of the data register.
    function automatic int action_bit(input int sr_width);
        return sr_width - 1;
    endfunction

endpackage

// File: rtl/jtag_dbg_sync_edge.sv
// Resynchronises an asynchronous JTAG update level and reports its rising edge.
module jtag_dbg_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic [SYNC_STAGES:0]   warm;
    logic                   hist;

    // Synchroniser chain, history flop and a warm-up marker that is only set
    // once the history flop holds a genuine post-reset sample, so a level that
    // was already high across reset release never looks like a new edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            warm  <= '0;
            hist  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
            warm  <= {warm[SYNC_STAGES-1:0], 1'b1};
            hist  <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~hist & warm[SYNC_STAGES];

endmodule

// File: rtl/jtag_debug_cmd_sync.sv
// System-clock front end of the JTAG debug module: detects update strobes,
// captures {ir, sr} into a small FIFO and issues per-instruction strobes.
module jtag_debug_cmd_sync
    import jtag_dbg_pkg::*;
#(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vs_udr,
    input  logic                  vs_uir,
    input  logic [IR_WIDTH-1:0]   ir_in,
    input  logic [SR_WIDTH-1:0]   sr,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [IR_WIDTH-1:0]   cmd_ir,
    output logic [SR_WIDTH-1:0]   jdo,
    output logic [2**IR_WIDTH-1:0] take_action,
    output logic [2**IR_WIDTH-1:0] take_no_action,
    output logic [IR_WIDTH-1:0]   cur_ir,
    output logic                  overflow,
    input  logic                  ovf_clear
);

    localparam int NCH     = 2**IR_WIDTH;
    localparam int AW      = clog2(FIFO_DEPTH);
    localparam int PW      = AW + 1;
    localparam int ACT_BIT = action_bit(SR_WIDTH);

    typedef struct packed {
        logic [IR_WIDTH-1:0] ir;
        logic [SR_WIDTH-1:0] data;
    } cmd_t;

    cmd_t           mem [FIFO_DEPTH];
    cmd_t           head;
    cmd_t           head_hold;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           udr_rise;
    logic           uir_rise;
    logic           full;
    logic           empty;
    logic           pop;
    logic           push;
    logic           drop;
    logic [NCH-1:0] head_sel;

    jtag_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_udr),
        .rise     (udr_rise)
    );

    jtag_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_uir),
        .rise     (uir_rise)
    );

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && cmd_ready;
    assign push  = udr_rise && (!full || pop);
    assign drop  = udr_rise && full && !pop;

    // Present the head entry, falling back to the last popped command when empty.
    always_comb begin
        head = head_hold;
        if (!empty) begin
            head = mem[rd_ptr[AW-1:0]];
        end
    end

    assign head_sel  = NCH'(1) << head.ir;
    assign cmd_valid = !empty;
    assign cmd_ir    = head.ir;
    assign jdo       = head.data;

    // FIFO storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{ir: ir_in, data: sr};
        end
    end

    // Pointer update, held-head register and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            head_hold <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                head_hold <= head;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // One-cycle per-instruction strobe following each accepted command.
    always_ff @(posedge clk) begin
        if (reset) begin
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (pop) begin
                if (head.data[ACT_BIT]) begin
                    take_action <= head_sel;
                end else begin
                    take_no_action <= head_sel;
                end
            end
        end
    end

    // Track the instruction register at every update-IR.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_ir <= '0;
        end else if (uir_rise) begin
            cur_ir <= ir_in;
        end
    end

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Directed, table-driven bench for jtag_debug_cmd_sync (default parameters).
module tb_jtag_debug_cmd_sync;

    logic        clk = 1'b0;
    logic        reset;
    logic        vs_udr;
    logic        vs_uir;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ir;
    logic [37:0] jdo;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic [1:0]  cur_ir;
    logic        overflow;
    logic        ovf_clear;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] data;
        logic [3:0]  act;
        logic [3:0]  noact;
    } vec_t;

    vec_t        vecs [6];
    logic [1:0]  fill_ir [6];
    logic [37:0] fill_sr [6];

    jtag_debug_cmd_sync dut (
        .clk            (clk),
        .reset          (reset),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_ir         (cmd_ir),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .cur_ir         (cur_ir),
        .overflow       (overflow),
        .ovf_clear      (ovf_clear)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] ir, input logic [37:0] data, input logic udr,
                                 input logic uir, input logic ready, input logic clr);
        ir_in     = ir;
        sr        = data;
        vs_udr    = udr;
        vs_uir    = uir;
        cmd_ready = ready;
        ovf_clear = clr;
    endtask

    // Full update-DR pulse: high 4 cycles, low 4 cycles.
    task automatic pulseUdr(input logic [1:0] ir, input logic [37:0] data, input logic ready);
        applyStimulus(ir, data, 1'b1, 1'b0, ready, 1'b0);
        tick(4);
        vs_udr = 1'b0;
        tick(4);
    endtask

    function automatic logic [3:0] expAct(input logic [1:0] ir, input logic [37:0] data);
        return data[37] ? (4'b0001 << ir) : 4'b0000;
    endfunction

    function automatic logic [3:0] expNoAct(input logic [1:0] ir, input logic [37:0] data);
        return data[37] ? 4'b0000 : (4'b0001 << ir);
    endfunction

    initial begin
        int seen;

        vecs[0] = '{2'd2, 38'h20_0000_00AB, 4'b0100, 4'b0000};
        vecs[1] = '{2'd1, 38'h00_1234_5678, 4'b0000, 4'b0010};
        vecs[2] = '{2'd0, 38'h3F_FFFF_FFFF, 4'b0001, 4'b0000};
        vecs[3] = '{2'd3, 38'h1F_FFFF_FFFF, 4'b0000, 4'b1000};
        vecs[4] = '{2'd2, 38'h02_0000_00AB, 4'b0000, 4'b0100};
        vecs[5] = '{2'd3, 38'h20_0000_0000, 4'b1000, 4'b0000};

        fill_ir[0] = 2'd0; fill_sr[0] = 38'h20_0000_0001;
        fill_ir[1] = 2'd1; fill_sr[1] = 38'h00_0000_0002;
        fill_ir[2] = 2'd2; fill_sr[2] = 38'h3F_0000_0003;
        fill_ir[3] = 2'd3; fill_sr[3] = 38'h1F_0000_0004;
        fill_ir[4] = 2'd1; fill_sr[4] = 38'h21_0000_0005;
        fill_ir[5] = 2'd2; fill_sr[5] = 38'h15_5555_5555;

        // Reset values
        reset = 1'b1;
        applyStimulus(2'd0, 38'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("rst cmd_valid", 64'(cmd_valid), 64'd0);
        checkOutput("rst jdo", 64'(jdo), 64'd0);
        checkOutput("rst cmd_ir", 64'(cmd_ir), 64'd0);
        checkOutput("rst take_action", 64'(take_action), 64'd0);
        checkOutput("rst take_no_action", 64'(take_no_action), 64'd0);
        checkOutput("rst cur_ir", 64'(cur_ir), 64'd0);
        checkOutput("rst overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        tick(4);

        // Update-IR: cur_ir follows at the third edge, FIFO untouched
        applyStimulus(2'd3, 38'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        checkOutput("uir edge k", 64'(cur_ir), 64'd0);
        tick(1);
        checkOutput("uir edge k+1", 64'(cur_ir), 64'd0);
        tick(1);
        checkOutput("uir edge k+2", 64'(cur_ir), 64'd3);
        checkOutput("uir fifo empty", 64'(cmd_valid), 64'd0);
        vs_uir = 1'b0;
        tick(4);

        // Single commands with cmd_ready held high
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].ir, vecs[i].data, 1'b1, 1'b0, 1'b1, 1'b0);
            tick(1);
            checkOutput("vec valid k", 64'(cmd_valid), 64'd0);
            tick(1);
            checkOutput("vec valid k+1", 64'(cmd_valid), 64'd0);
            tick(1);
            checkOutput("vec valid k+2", 64'(cmd_valid), 64'd1);
            checkOutput("vec jdo", 64'(jdo), 64'(vecs[i].data));
            checkOutput("vec cmd_ir", 64'(cmd_ir), 64'(vecs[i].ir));
            checkOutput("vec no early strobe", 64'({take_action, take_no_action}), 64'd0);
            tick(1);
            checkOutput("vec take_action", 64'(take_action), 64'(vecs[i].act));
            checkOutput("vec take_no_action", 64'(take_no_action), 64'(vecs[i].noact));
            checkOutput("vec valid after pop", 64'(cmd_valid), 64'd0);
            checkOutput("vec jdo held", 64'(jdo), 64'(vecs[i].data));
            tick(1);
            checkOutput("vec strobe ends", 64'({take_action, take_no_action}), 64'd0);
            vs_udr = 1'b0;
            tick(4);
        end
        checkOutput("cur_ir unaffected by dr", 64'(cur_ir), 64'd3);

        // Fill to overflow with cmd_ready low
        for (int i = 0; i < 5; i++) begin
            pulseUdr(fill_ir[i], fill_sr[i], 1'b0);
            if (i == 3) begin
                checkOutput("fill no ovf at 4", 64'(overflow), 64'd0);
            end
        end
        checkOutput("fill ovf at 5", 64'(overflow), 64'd1);

        // Drop and ovf_clear in the same cycle: set wins
        applyStimulus(fill_ir[5], fill_sr[5], 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("clr before drop", 64'(overflow), 64'd0);
        tick(1);
        checkOutput("clr still low", 64'(overflow), 64'd0);
        tick(1);
        checkOutput("drop beats clear", 64'(overflow), 64'd1);
        ovf_clear = 1'b0;
        vs_udr    = 1'b0;
        tick(4);

        // Drain: first four commands in order
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain valid", 64'(cmd_valid), 64'd1);
            checkOutput("drain jdo", 64'(jdo), 64'(fill_sr[i]));
            checkOutput("drain cmd_ir", 64'(cmd_ir), 64'(fill_ir[i]));
            if (i > 0) begin
                checkOutput("drain strobe", 64'({take_action, take_no_action}),
                            64'({expAct(fill_ir[i-1], fill_sr[i-1]), expNoAct(fill_ir[i-1], fill_sr[i-1])}));
            end
            tick(1);
        end
        checkOutput("drain last strobe", 64'({take_action, take_no_action}),
                    64'({expAct(fill_ir[3], fill_sr[3]), expNoAct(fill_ir[3], fill_sr[3])}));
        checkOutput("drain empty", 64'(cmd_valid), 64'd0);
        checkOutput("drain ovf sticky", 64'(overflow), 64'd1);
        cmd_ready = 1'b0;
        ovf_clear = 1'b1;
        tick(1);
        ovf_clear = 1'b0;
        checkOutput("ovf cleared", 64'(overflow), 64'd0);

        // Full FIFO: pop and write on the same edge
        for (int i = 0; i < 4; i++) begin
            pulseUdr(fill_ir[i], fill_sr[i], 1'b0);
        end
        applyStimulus(fill_ir[4], fill_sr[4], 1'b1, 1'b0, 1'b0, 1'b0);
        tick(2);
        cmd_ready = 1'b1;
        tick(1);
        checkOutput("simul no ovf", 64'(overflow), 64'd0);
        checkOutput("simul strobe", 64'({take_action, take_no_action}),
                    64'({expAct(fill_ir[0], fill_sr[0]), expNoAct(fill_ir[0], fill_sr[0])}));
        for (int i = 1; i < 5; i++) begin
            checkOutput("simul jdo", 64'(jdo), 64'(fill_sr[i]));
            tick(1);
        end
        checkOutput("simul empty", 64'(cmd_valid), 64'd0);
        checkOutput("simul still no ovf", 64'(overflow), 64'd0);
        cmd_ready = 1'b0;
        vs_udr    = 1'b0;
        tick(4);

        // Reset mid-operation with update-DR held high through release
        pulseUdr(fill_ir[0], fill_sr[0], 1'b0);
        pulseUdr(fill_ir[1], fill_sr[1], 1'b0);
        checkOutput("pre-reset queued", 64'(cmd_valid), 64'd1);
        applyStimulus(fill_ir[2], fill_sr[2], 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (cmd_valid) seen++;
        end
        checkOutput("no cmd from held level", 64'(seen), 64'd0);
        checkOutput("post-rst jdo", 64'(jdo), 64'd0);
        checkOutput("post-rst cmd_ir", 64'(cmd_ir), 64'd0);
        checkOutput("post-rst strobes", 64'({take_action, take_no_action}), 64'd0);
        checkOutput("post-rst cur_ir", 64'(cur_ir), 64'd0);
        checkOutput("post-rst overflow", 64'(overflow), 64'd0);
        vs_udr = 1'b0;
        tick(4);
        applyStimulus(fill_ir[3], fill_sr[3], 1'b1, 1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("new edge valid", 64'(cmd_valid), 64'd1);
        checkOutput("new edge jdo", 64'(jdo), 64'(fill_sr[3]));
        vs_udr = 1'b0;
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
